// File: rtl/duft_arb_pkg.sv
// Shared types and constants for the DUFT access arbiter.
// State encoding, default timeout/error data and bus widths.
package duft_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam int DEF_TIMEOUT_CYC = 16;
    localparam logic [DATA_W-1:0] DEF_ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/duft_rr_picker.sv
// Combinational round-robin selector.
// Searches from the requester after i_last, wrapping around.
module duft_rr_picker
    import duft_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [NREQ-1:0]  o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        int   w_c;
        logic w_found;
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_c     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_c = (int'(i_last) + k) % NREQ;
            if (!w_found && i_req[w_c]) begin
                w_found       = 1'b1;
                o_grant[w_c]  = 1'b1;
                o_idx         = IDX_W'(w_c);
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/duft_access_arbiter.sv
// Round-robin sequencer sharing one ap_ctrl_hs DUFT port
// between NREQ requesters, with a hung-port timeout.
module duft_access_arbiter
    import duft_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter logic [DATA_W-1:0] ERR_DATA = DEF_ERR_DATA
) (
    input  logic                   clk,
    input  logic                   ap_rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_rd_wr,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]      resp_data,
    output logic                   resp_err,
    output logic                   ap_start,
    output logic [ADDR_W-1:0]      addr,
    output logic [DATA_W-1:0]      wr_data,
    output logic                   rd_wr,
    input  logic                   ap_idle,
    input  logic                   ap_done,
    input  logic                   ap_ready,
    input  logic [DATA_W-1:0]      ap_return
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    arb_state_e        r_state;
    arb_state_e        w_next;
    logic [IDX_W-1:0]  r_owner;
    logic [IDX_W-1:0]  r_last;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ap_start;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rd_wr;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_err;

    logic [NREQ-1:0]   w_grant;
    logic [IDX_W-1:0]  w_idx;
    logic              w_any;
    logic              w_take;
    logic              w_timeout;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_rd_wr;

    duft_rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req   (req_valid),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // ap_idle low means the DUFT is still coming out of reset
    assign w_take    = (r_state == IDLE) && ap_idle && w_any;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_rd_wr = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                w_sel_rd_wr = req_rd_wr[i];
            end
        end
    end

    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = '0;
        resp_valid = '0;
        unique case (r_state)
            IDLE: begin
                if (w_take) begin
                    req_ready = w_grant;
                    w_next    = ISSUE;
                end
            end
            ISSUE: begin
                if (ap_done || w_timeout) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                resp_valid = NREQ'(1) << r_owner;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_owner     <= '0;
            r_last      <= IDX_W'(NREQ - 1);
            r_cnt       <= '0;
            r_ap_start  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rd_wr     <= 1'b1;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_addr     <= w_sel_addr;
                        r_wdata    <= w_sel_wdata;
                        r_rd_wr    <= w_sel_rd_wr;
                        r_ap_start <= 1'b1;
                        r_owner    <= w_idx;
                        r_last     <= w_idx;
                        r_cnt      <= '0;
                    end
                end
                ISSUE: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // done beats a timeout landing in the same cycle
                    if (ap_done) begin
                        r_ap_start  <= 1'b0;
                        r_resp_data <= r_rd_wr ? ap_return : '0;
                        r_resp_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_ap_start  <= 1'b0;
                        r_resp_data <= ERR_DATA;
                        r_resp_err  <= 1'b1;
                    end
                end
                RESP: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign ap_start  = r_ap_start;
    assign addr      = r_addr;
    assign wr_data   = r_wdata;
    assign rd_wr     = r_rd_wr;
    assign resp_data = r_resp_data;
    assign resp_err  = r_resp_err;

    a_done_ready: assert property (
        @(posedge clk) disable iff (!ap_rst_n)
        ap_done |-> ap_ready
    );

endmodule

// File: tb/tb_duft_access_arbiter.sv
// Scoreboard bench for duft_access_arbiter with a reactive DUFT
// model, a round-robin reference and randomized traffic.
module tb_duft_access_arbiter;

    localparam int NREQ = 2;
    localparam int TO   = 16;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               ap_rst_n = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_rd_wr = '0;
    logic [NREQ*32-1:0] req_addr = '0;
    logic [NREQ*32-1:0] req_wdata = '0;
    logic [NREQ-1:0]    resp_valid;
    logic [31:0]        resp_data;
    logic               resp_err;
    logic               ap_start;
    logic [31:0]        addr;
    logic [31:0]        wr_data;
    logic               rd_wr;
    logic               ap_idle = 1'b0;
    logic               ap_done = 1'b0;
    logic               ap_ready = 1'b0;
    logic [31:0]        ap_return = '0;

    duft_access_arbiter #(
        .NREQ        (NREQ),
        .TIMEOUT_CYC (TO),
        .ERR_DATA    (ERRD)
    ) dut (
        .clk        (clk),
        .ap_rst_n   (ap_rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rd_wr  (req_rd_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .ap_start   (ap_start),
        .addr       (addr),
        .wr_data    (wr_data),
        .rd_wr      (rd_wr),
        .ap_idle    (ap_idle),
        .ap_done    (ap_done),
        .ap_ready   (ap_ready),
        .ap_return  (ap_return)
    );

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   mode = 0;
    int   lat_k = 2;
    bit   chk_spacing = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] f_ret(input logic [31:0] a);
        return 32'hA5A5_0000 ^ (a >> 4);
    endfunction

    // cycles of ap_start high until the DUFT answers
    function automatic int k_for(input logic rw, input logic [31:0] a,
                                 input int md, input int lk);
        case (md)
            0:       return rw ? 2 : 3;
            1:       return 1000;
            2:       return lk;
            default: return (int'(a[6:2]) % 20) + 1;
        endcase
    endfunction

    // reference model: round robin + payload snapshot
    int          last_g = NREQ - 1;
    int          g_first = -1;
    int          prev_g = 0;
    bit          sp_armed = 1'b0;
    logic [31:0] s_addr = '0;
    logic [31:0] s_wdata = '0;
    logic        s_rw = 1'b1;

    always @(negedge clk) begin
        int w;
        int c;
        int id;
        int hit;
        if (!ap_rst_n) begin
            last_g   = NREQ - 1;
            g_first  = -1;
            sp_armed = 1'b0;
        end else begin
            if (!chk_spacing) sp_armed = 1'b0;
            if (resp_valid != '0) begin
                chk("ready_during_resp", 32'(req_ready), 0);
                chk("resp_onehot", $countones(resp_valid), 1);
                id = -1;
                for (int i = NREQ - 1; i >= 0; i--)
                    if (resp_valid[i]) id = i;
                hit = -1;
                for (int j = sb.size() - 1; j >= 0; j--)
                    if (sb[j].id == id) hit = j;
                if (hit < 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_resp: got resp_valid %b want none",
                             resp_valid);
                end else begin
                    chk("resp_data", resp_data, sb[hit].data);
                    chk("resp_err", 32'(resp_err), 32'(sb[hit].err));
                    sb.delete(hit);
                end
            end
            if (req_ready != '0) begin
                w = -1;
                for (int j = NREQ; j >= 1; j--) begin
                    c = (last_g + j) % NREQ;
                    if (req_valid[c]) w = c;
                end
                chk("grant_ap_idle", 32'(ap_idle), 1);
                chk("grant_winner", 32'(req_ready),
                    (w < 0) ? 0 : (1 << w));
                if (w >= 0) begin
                    last_g  = w;
                    s_addr  = req_addr[w*32 +: 32];
                    s_wdata = req_wdata[w*32 +: 32];
                    s_rw    = req_rd_wr[w];
                    if (g_first < 0) g_first = w;
                end
                if (chk_spacing) begin
                    if (sp_armed) chk("grant_spacing", cyc - prev_g, 4);
                    sp_armed = 1'b1;
                    prev_g   = cyc;
                end
            end
        end
    end

    // DUFT port model: answers after k_for() cycles of ap_start
    int hi = 0;
    always @(negedge clk) begin
        int kk;
        if (!ap_rst_n || ap_start !== 1'b1) begin
            hi        = 0;
            ap_done   = 1'b0;
            ap_ready  = 1'b0;
            ap_return = $urandom;
        end else begin
            hi++;
            chk("cmd_addr", addr, s_addr);
            chk("cmd_wdata", wr_data, s_wdata);
            chk("cmd_rd_wr", 32'(rd_wr), 32'(s_rw));
            kk        = k_for(s_rw, s_addr, mode, lat_k);
            ap_done   = (hi == kk);
            ap_ready  = ap_done;
            ap_return = ap_done ? f_ret(s_addr) : $urandom;
        end
    end

    task automatic req_do(input int i, input logic rw,
                          input logic [31:0] a, input logic [31:0] d,
                          input bit exp_resp);
        int   k;
        bit   got;
        exp_t e;
        k = k_for(rw, a, mode, lat_k);
        if (exp_resp) begin
            e.id   = i;
            e.err  = (k > TO);
            e.data = e.err ? ERRD : (rw ? f_ret(a) : 32'h0);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_rd_wr[i]        = rw;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = d;
        req_valid[i]        = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL grant_wait: got no req_ready for req %0d want grant", i);
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    // called right after req_do returns (first negedge is T+1)
    task automatic track(input string nm, input int ehi, input int eoff);
        int first = -1;
        int nhi = 0;
        int roff = -1;
        for (int off = 1; off <= 60; off++) begin
            @(negedge clk);
            if (ap_start) begin
                if (first < 0) first = off;
                nhi++;
            end
            if (resp_valid != '0) begin
                roff = off;
                break;
            end
        end
        chk({nm, "_start_off"}, first, 1);
        chk({nm, "_hi_cycles"}, nhi, ehi);
        chk({nm, "_resp_off"}, roff, eoff);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && !ap_start && resp_valid == '0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain", 32'(ok), 1);
    endtask

    task automatic rand_stream(input int i, input int cnt);
        for (int n = 0; n < cnt; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            req_do(i, 1'($urandom), $urandom & 32'h0000_FFFC,
                   $urandom, 1'b1);
        end
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_ap_start"}, 32'(ap_start), 0);
        chk({nm, "_addr"}, addr, 0);
        chk({nm, "_wr_data"}, wr_data, 0);
        chk({nm, "_rd_wr"}, 32'(rd_wr), 1);
        chk({nm, "_resp_data"}, resp_data, 0);
        chk({nm, "_resp_err"}, 32'(resp_err), 0);
        chk({nm, "_resp_valid"}, 32'(resp_valid), 0);
        chk({nm, "_req_ready"}, 32'(req_ready), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outs("por");
        @(posedge clk);
        #1 ap_rst_n = 1'b1;

        // DUFT not idle yet, then first read from req 0
        fork
            req_do(0, 1'b1, 32'h10, 32'h0, 1'b1);
            begin
                @(posedge clk);
                #2;
                repeat (3) begin
                    @(negedge clk);
                    chk("idle_block", 32'(req_ready), 0);
                end
                @(posedge clk);
                #1 ap_idle = 1'b1;
            end
        join
        track("rd0", 2, 3);

        req_do(1, 1'b0, 32'h20, 32'h1234, 1'b1);
        track("wr1", 3, 4);

        chk_spacing = 1'b1;
        fork
            for (int n = 0; n < 4; n++)
                req_do(0, 1'b1, 32'h100 + 32'(n * 4), 32'h0, 1'b1);
            for (int n = 0; n < 4; n++)
                req_do(1, 1'b1, 32'h200 + 32'(n * 4), 32'h0, 1'b1);
        join
        drain();
        chk_spacing = 1'b0;

        mode = 1;
        req_do(0, 1'b1, 32'h30, 32'h0, 1'b1);
        track("hang", 16, 17);
        mode = 0;
        req_do(1, 1'b1, 32'h34, 32'h0, 1'b1);
        track("after_to", 2, 3);

        mode  = 2;
        lat_k = 16;
        req_do(0, 1'b1, 32'h44, 32'h0, 1'b1);
        track("k16", 16, 17);
        lat_k = 17;
        req_do(1, 1'b1, 32'h48, 32'h0, 1'b1);
        track("k17", 16, 17);
        lat_k = 1;
        req_do(0, 1'b1, 32'h4C, 32'h0, 1'b1);
        track("k1", 1, 2);

        // reset in the middle of a hung write
        mode = 1;
        req_do(0, 1'b0, 32'h40, 32'hCAFE, 1'b0);
        repeat (3) @(negedge clk);
        #1 ap_rst_n = 1'b0;
        #1 chk_reset_outs("mid_rst");
        repeat (2) @(posedge clk);
        #1 ap_rst_n = 1'b1;
        mode = 0;
        fork
            req_do(0, 1'b1, 32'h80, 32'h0, 1'b1);
            req_do(1, 1'b1, 32'h90, 32'h0, 1'b1);
        join
        drain();
        chk("first_grant_after_reset", g_first, 0);

        mode = 3;
        fork
            rand_stream(0, 30);
            rand_stream(1, 30);
        join
        drain();

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion want $finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/duft_access_arbiter.md
Name: duft_access_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single DUFT ap_ctrl_hs transaction port (addr, wr_data, rd_wr, ap_start, ap_done, ap_return) between NREQ independent requesters, such as a host bridge and a debug scan engine.
- Issues one transaction at a time and holds the command stable until the DUFT port signals done.
- Returns read data and a completion to the owning requester.
- Guards against a hung port with a timeout.

Parameters:
NREQ, 2, number of requesters (2..8)
TIMEOUT_CYC, 16, max cycles ap_start may stay high without ap_done before abort
ERR_DATA, 32'hDEADBEEF, resp_data value returned on timeout

Ports:
clk  input  1  clock, rising edge
ap_rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  request pending, per requester; held until req_ready
req_ready  output  NREQ  one-cycle accept pulse, one-hot or zero
req_rd_wr  input  NREQ  1 = read, 0 = write
req_addr  input  NREQ*32  flattened addresses, requester i at [32i+31:32i]
req_wdata  input  NREQ*32  flattened write data
resp_valid  output  NREQ  one-cycle completion pulse to the owner
resp_data  output  32  read data (write: 0); valid with resp_valid
resp_err  output  1  timeout flag; valid with resp_valid
ap_start  output  1  to DUFT port, registered
addr  output  32  to DUFT port, registered
wr_data  output  32  to DUFT port, registered
rd_wr  output  1  to DUFT port, registered
ap_idle  input  1  from DUFT port
ap_done  input  1  from DUFT port
ap_ready  input  1  from DUFT port (monitored only)
ap_return  input  32  from DUFT port, sampled when ap_done=1

Behaviour:
- Reset (async, ap_rst_n=0):
  - state=IDLE; ap_start=0; addr, wr_data, resp_data=0; rd_wr=1.
  - req_ready, resp_valid=0; resp_err=0; timeout counter=0.
  - Round-robin pointer set so requester 0 has highest priority.
- Reset mid-transaction: abort immediately to the reset values. No resp_valid is issued for the aborted transaction.
- IDLE state:
  - If ap_idle=1 and any req_valid, the winner is the first asserted requester at or after (last_grant+1) mod NREQ.
  - req_ready[winner]=1 combinationally in the same cycle (T).
  - Latch req_addr, req_wdata and req_rd_wr into addr, wr_data and rd_wr. Set ap_start<=1. Record the owner and update last_grant. Go to ISSUE.
  - If ap_idle=0 (DUFT still in its reset state), no grant is made.
- ISSUE state:
  - ap_start, addr, wr_data and rd_wr are held stable.
  - Counter increments each cycle.
  - On ap_done=1: resp_data<=ap_return for reads or 0 for writes; resp_err<=0; ap_start<=0 at that same edge, so the DUFT never sees a back-to-back start; go to RESP.
  - If ap_done has not arrived when the counter reaches TIMEOUT_CYC-1: ap_start<=0; resp_data<=ERR_DATA; resp_err<=1; go to RESP.
  - If ap_done and the timeout occur in the same cycle, ap_done wins.
- RESP state:
  - resp_valid[owner]=1 for exactly one cycle. Counter cleared. Go to IDLE.
  - A new grant is possible on the next cycle.
- Latency:
  - Read: accept at T, ap_start high at T+1, ap_done at T+2, resp_valid at T+3.
  - Write: ap_done at T+3, resp_valid at T+4.
  - Minimum spacing between successive grants is 4 cycles for reads and 5 for writes.
- Requester requirements:
  - A requester must keep req_valid and its payload stable until req_ready.
  - A requester dropping req_valid before grant is legal and simply loses arbitration.
- Round-robin fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 grants.
- ap_ready is not used for control. A simulation-only assertion checks that ap_done implies ap_ready.
- Counter width is $clog2(TIMEOUT_CYC)+1.

Decomposition:
- Package duft_arb_pkg holds:
  - state encoding IDLE=0, ISSUE=1, RESP=2;
  - default TIMEOUT_CYC and ERR_DATA;
  - the widths ADDR_W=32 and DATA_W=32.
- One sub-module, duft_rr_picker: combinational round-robin selector with inputs req vector and last_grant, outputs one-hot grant and index. The FSM, datapath registers and timeout logic stay in the top.

Test Plan:
1. Reset release, req 0 read addr 0x10, DUFT returns 0xA5A5_0001 -> req_ready[0] at T, ap_start high only during T+1..T+2, resp_valid[0] at T+3 with resp_data=0xA5A50001, resp_err=0.
2. Req 1 write addr 0x20 data 0x1234 -> addr and wr_data stable while ap_start=1, ap_start falls after ap_done at T+3, resp_valid[1] at T+4, resp_data=0.
3. Both requesters valid continuously with reads -> grants alternate 0,1,0,1 with 4-cycle spacing; no grant while resp_valid is high.
4. DUFT model never asserts ap_done -> ap_start drops after 16 cycles, resp_valid with resp_err=1 and resp_data=0xDEADBEEF, arbiter returns to IDLE and serves the next request normally.
5. Assert ap_rst_n low during ISSUE of a write -> all outputs at reset values immediately (asynchronous), no resp_valid; after release, the first grant goes to requester 0.
6. ap_idle held 0 for 3 cycles after reset with req 0 valid -> no req_ready until the cycle ap_idle=1.
